prism_counter_bank: RTL and testbench

Parametrised bank of countdown counters for the PRISM peripheral. It is the generalised successor of the fixed 27-bit and 4-bit counter pair, with NUM_CNT independent channels of CNT_W bits. Each channel adds one-shot or auto-reload mode, software load, sticky zero events and maskable interrupts. The block sits between the TinyQV bus slice and the PRISM FSM:

- the FSM drives the per-channel `dec`/`load` strobes;
- the block returns the `zero` flags as FSM inputs.

---
 rtl/prism_counter_bank_pkg.sv | 23 ++
 rtl/prism_counter_bank_if.sv | 25 ++
 rtl/prism_counter_bank_chan.sv | 70 +++++++
 rtl/prism_counter_bank.sv | 112 +++++++++++
 tb/tb_prism_counter_bank.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prism_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prism_cnt_pkg
// Brief    : Register map and shared constants for the PRISM counter bank.
// Revision : 1.0
// ============================================================================
package prism_cnt_pkg;

    localparam logic [5:0] ADDR_STATUS   = 6'h00;
    localparam logic [5:0] ADDR_IRQ_EN   = 6'h04;
    localparam logic [5:0] ADDR_MODE     = 6'h08;
    localparam logic [5:0] ADDR_CNT_BASE = 6'h20;

    localparam int MAX_CNT    = 8;
    localparam int SWLOAD_LSB = 8;

    // Byte address of channel idx's PRELOAD/COUNT word.
    function automatic logic [5:0] chan_addr(input int idx);
        return ADDR_CNT_BASE + 6'(idx * 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prism_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : prism_counter_bank_if
// Brief    : TinyQV peripheral bus slice as seen by the PRISM counter bank.
// Revision : 1.0
// ============================================================================
interface prism_counter_bank_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface
`default_nettype wire

// File: rtl/prism_counter_bank_chan.sv
`default_nettype none
// ============================================================================
// Module   : prism_cnt_chan
// Brief    : One countdown channel: COUNT, PRELOAD, terminal pulse, priority.
// Revision : 1.0
// ============================================================================
module prism_cnt_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_load,
    input  logic             preload_we,
    input  logic [CNT_W-1:0] preload_d,
    input  logic             dec,
    input  logic             load,
    input  logic             halt,
    input  logic             enable,
    input  logic             auto,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             term
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_preload;
    logic             r_term;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_term;

    // Software load beats halt; dec at zero falls through to the FSM load.
    always_comb begin
        w_count_nxt = r_count;
        w_term      = 1'b0;
        if (sw_load) begin
            w_count_nxt = r_preload;
        end else if (halt) begin
            w_count_nxt = r_count;
        end else if (dec && (r_count != '0)) begin
            if (r_count == CNT_W'(1)) begin
                w_term      = 1'b1;
                w_count_nxt = auto ? r_preload : '0;
            end else begin
                w_count_nxt = r_count - CNT_W'(1);
            end
        end else if (enable && load) begin
            w_count_nxt = r_preload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_preload <= '0;
            r_term    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_term  <= w_term;
            if (preload_we) begin
                r_preload <= preload_d;
            end
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0) | r_term;
    assign term  = w_term;

endmodule
`default_nettype wire

// File: rtl/prism_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : prism_counter_bank
// Brief    : Bank of NUM_CNT countdown channels with status, IRQ and bus map.
// Revision : 1.0
// ============================================================================
module prism_counter_bank #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prism_counter_bank_if.slave  bus,
    input  logic                 fsm_enable,
    input  logic                 fsm_halt,
    input  logic [NUM_CNT-1:0]   dec,
    input  logic [NUM_CNT-1:0]   load,
    output logic [NUM_CNT-1:0]   zero,
    output logic                 irq
);
    import prism_cnt_pkg::*;

    generate
        if ((NUM_CNT < 1) || (NUM_CNT > MAX_CNT) || (CNT_W < 1) || (CNT_W > 32)) begin : g_bad_params
            $error("prism_counter_bank: NUM_CNT must be 1..8 and CNT_W 1..32");
        end
    endgenerate

    logic               w_wr32;
    logic               w_wr_status;
    logic               w_wr_irq_en;
    logic               w_wr_mode;
    logic [NUM_CNT-1:0] w_sw_load;
    logic [NUM_CNT-1:0] w_term;
    logic [NUM_CNT-1:0] r_status;
    logic [NUM_CNT-1:0] r_irq_en;
    logic [NUM_CNT-1:0] r_auto;
    logic [CNT_W-1:0]   w_count [NUM_CNT];
    logic               w_unused_bits;

    // Narrow writes are deliberately ignored by every register.
    assign w_wr32      = (bus.data_write_n == 2'b10);
    assign w_wr_status = w_wr32 && (bus.address == ADDR_STATUS);
    assign w_wr_irq_en = w_wr32 && (bus.address == ADDR_IRQ_EN);
    assign w_wr_mode   = w_wr32 && (bus.address == ADDR_MODE);
    assign w_sw_load   = w_wr_mode ? bus.data_in[SWLOAD_LSB +: NUM_CNT] : '0;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_chan
            logic w_pre_we;
            assign w_pre_we = w_wr32 && (bus.address == chan_addr(gi));

            prism_cnt_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .sw_load    (w_sw_load[gi]),
                .preload_we (w_pre_we),
                .preload_d  (bus.data_in[CNT_W-1:0]),
                .dec        (dec[gi]),
                .load       (load[gi]),
                .halt       (fsm_halt),
                .enable     (fsm_enable),
                .auto       (r_auto[gi]),
                .count      (w_count[gi]),
                .zero       (zero[gi]),
                .term       (w_term[gi])
            );
        end
    endgenerate

    // A hardware terminal event outranks a simultaneous W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= '0;
            r_irq_en <= '0;
            r_auto   <= '0;
        end else begin
            r_status <= (r_status & ~(w_wr_status ? bus.data_in[NUM_CNT-1:0] : '0)) | w_term;
            if (w_wr_irq_en) begin
                r_irq_en <= bus.data_in[NUM_CNT-1:0];
            end
            if (w_wr_mode) begin
                r_auto <= bus.data_in[NUM_CNT-1:0];
            end
        end
    end

    assign irq = |(r_status & r_irq_en);

    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            ADDR_STATUS: bus.data_out = 32'(r_status);
            ADDR_IRQ_EN: bus.data_out = 32'(r_irq_en);
            ADDR_MODE:   bus.data_out = 32'(r_auto);
            default: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (bus.address == chan_addr(i)) begin
                        bus.data_out = 32'(w_count[i]);
                    end
                end
            end
        endcase
    end

    assign bus.data_ready = 1'b1;
    assign w_unused_bits  = ^{bus.data_read_n, bus.data_in};

endmodule
`default_nettype wire

// File: tb/tb_prism_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_prism_counter_bank
// Brief    : Directed and randomized self-checking bench for the counter bank.
// Revision : 1.0
// ============================================================================
module tb_prism_counter_bank;

    localparam int          NUM_CNT  = 4;
    localparam int          CNT_W    = 16;
    localparam logic [31:0] CNT_MASK = 32'h0000_FFFF;

    logic               clk;
    logic               rst_n;
    logic               fsm_enable;
    logic               fsm_halt;
    logic [NUM_CNT-1:0] dec;
    logic [NUM_CNT-1:0] load;
    logic [NUM_CNT-1:0] zero;
    logic               irq;

    int n_checks;
    int n_pass;

    // Behavioural model state
    int unsigned m_cnt [NUM_CNT];
    int unsigned m_pre [NUM_CNT];
    logic [NUM_CNT-1:0] m_status, m_irq_en, m_auto, m_term;

    prism_counter_bank_if bus_if ();

    prism_counter_bank #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .fsm_enable (fsm_enable),
        .fsm_halt   (fsm_halt),
        .dec        (dec),
        .load       (load),
        .zero       (zero),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NUM_CNT; i++) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
        end
        m_status = '0;
        m_irq_en = '0;
        m_auto   = '0;
        m_term   = '0;
    endtask

    // Applies one clock's worth of register-map and channel rules to the model.
    task automatic model_step();
        logic               wr;
        logic [31:0]        d;
        logic [5:0]         a;
        logic [NUM_CNT-1:0] hits;
        int unsigned        nc [NUM_CNT];
        wr   = (bus_if.data_write_n == 2'b10);
        d    = bus_if.data_in;
        a    = bus_if.address;
        hits = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (wr && a == 6'h08 && d[8+i]) nc[i] = m_pre[i];
            else if (fsm_halt) nc[i] = m_cnt[i];
            else if (dec[i] && m_cnt[i] != 0) begin
                if (m_cnt[i] == 1) begin
                    hits[i] = 1'b1;
                    nc[i]   = m_auto[i] ? m_pre[i] : 0;
                end else begin
                    nc[i] = m_cnt[i] - 1;
                end
            end else if (fsm_enable && load[i]) nc[i] = m_pre[i];
            else nc[i] = m_cnt[i];
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            m_cnt[i] = nc[i];
            if (wr && a == 6'(32 + 4 * i)) m_pre[i] = d & CNT_MASK;
        end
        if (wr && a == 6'h00) m_status = m_status & ~d[NUM_CNT-1:0];
        m_status = m_status | hits;
        if (wr && a == 6'h04) m_irq_en = d[NUM_CNT-1:0];
        if (wr && a == 6'h08) m_auto = d[NUM_CNT-1:0];
        m_term = hits;
    endtask

    function automatic logic [31:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return 32'(m_status);
        if (a == 6'h04) return 32'(m_irq_en);
        if (a == 6'h08) return 32'(m_auto);
        for (int i = 0; i < NUM_CNT; i++)
            if (a == 6'(32 + 4 * i)) return m_cnt[i];
        return 32'h0;
    endfunction

    function automatic logic [NUM_CNT-1:0] m_zero();
        logic [NUM_CNT-1:0] z;
        for (int i = 0; i < NUM_CNT; i++) z[i] = (m_cnt[i] == 0) || m_term[i];
        return z;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        bus_if.data_write_n = 2'b11;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        bus_if.address      = a;
        bus_if.data_in      = d;
        bus_if.data_write_n = wn;
        tick();
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        bus_if.address      = a;
        bus_if.data_write_n = 2'b11;
        #1;
        d = bus_if.data_out;
    endtask

    task automatic test_reset();
        logic [5:0]  addrs [7] = '{6'h00, 6'h04, 6'h08, 6'h20, 6'h24, 6'h28, 6'h2C};
        logic [31:0] rd;
        rst_n = 1'b0;
        fsm_enable = 1'b0; fsm_halt = 1'b0; dec = '0; load = '0;
        bus_if.address = '0; bus_if.data_in = '0;
        bus_if.data_write_n = 2'b11; bus_if.data_read_n = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        n_checks++;
        if (zero !== 4'hF) $display("FAIL reset_zero: got %h expected %h", zero, 4'hF);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
        else n_pass++;
        n_checks++;
        if (bus_if.data_ready !== 1'b1) $display("FAIL data_ready: got %b expected 1", bus_if.data_ready);
        else n_pass++;
        foreach (addrs[k]) begin
            bus_read(addrs[k], rd);
            n_checks++;
            if (rd !== 32'h0) $display("FAIL reset_read @%h: got %h expected 0", addrs[k], rd);
            else n_pass++;
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] rd;
        bus_write(6'h20, 32'd3, 2'b10);
        bus_write(6'h08, 32'h100, 2'b10);
        bus_read(6'h20, rd);
        n_checks++;
        if (rd !== 32'd3) $display("FAIL oneshot_swload: got %0d expected 3", rd);
        else n_pass++;
        dec = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus_read(6'h20, rd);
            n_checks++;
            if (rd !== 32'(k < 3 ? 3 - k : 0)) $display("FAIL oneshot_count step%0d: got %0d expected %0d", k, rd, (k < 3 ? 3 - k : 0));
            else n_pass++;
        end
        dec = '0;
        n_checks++;
        if (zero[0] !== 1'b1) $display("FAIL oneshot_zero: got %b expected 1", zero[0]);
        else n_pass++;
        bus_read(6'h00, rd);
        n_checks++;
        if (rd !== 32'h1) $display("FAIL oneshot_status: got %h expected 1", rd);
        else n_pass++;
        bus_write(6'h00, 32'h1, 2'b10);
        bus_read(6'h00, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL oneshot_w1c: got %h expected 0", rd);
        else n_pass++;
    endtask

    task automatic test_auto_irq();
        logic [31:0] rd;
        bus_write(6'h08, 32'h2, 2'b10);
        bus_write(6'h04, 32'h2, 2'b10);
        bus_write(6'h24, 32'd2, 2'b10);
        fsm_enable = 1'b1; load = 4'b0010;
        tick();
        load = '0;
        dec  = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus_read(6'h24, rd);
            n_checks++;
            if (rd !== 32'((k % 2 == 1) ? 1 : 2)) $display("FAIL auto_count k%0d: got %0d expected %0d", k, rd, ((k % 2 == 1) ? 1 : 2));
            else n_pass++;
            n_checks++;
            if (zero[1] !== (k % 2 == 0)) $display("FAIL auto_zero_pulse k%0d: got %b expected %b", k, zero[1], (k % 2 == 0));
            else n_pass++;
            n_checks++;
            if (irq !== (k >= 2)) $display("FAIL auto_irq k%0d: got %b expected %b", k, irq, (k >= 2));
            else n_pass++;
        end
        bus_write(6'h00, 32'h2, 2'b10);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL w1c_irq_drop: got %b expected 0", irq);
        else n_pass++;
        bus_write(6'h00, 32'h2, 2'b10);
        dec = '0;
        n_checks++;
        if (irq !== 1'b1) $display("FAIL w1c_vs_set: got %b expected 1", irq);
        else n_pass++;
        bus_read(6'h00, rd);
        n_checks++;
        if (rd !== 32'h2) $display("FAIL w1c_vs_set_status: got %h expected 2", rd);
        else n_pass++;
        bus_write(6'h00, 32'hF, 2'b10);
    endtask

    task automatic test_halt_enable();
        logic [31:0] rd;
        bus_write(6'h28, 32'd5, 2'b10);
        bus_write(6'h08, 32'h400, 2'b10);
        fsm_halt = 1'b1; dec = 4'b0100;
        repeat (10) tick();
        bus_read(6'h28, rd);
        n_checks++;
        if (rd !== 32'd5) $display("FAIL halt_hold: got %0d expected 5", rd);
        else n_pass++;
        fsm_halt = 1'b0; fsm_enable = 1'b0;
        tick();
        dec = '0; load = 4'b0100;
        tick();
        bus_read(6'h28, rd);
        n_checks++;
        if (rd !== 32'd4) $display("FAIL load_gated: got %0d expected 4", rd);
        else n_pass++;
        fsm_halt = 1'b1;
        bus_write(6'h08, 32'h400, 2'b10);
        bus_read(6'h28, rd);
        n_checks++;
        if (rd !== 32'd5) $display("FAIL swload_halted: got %0d expected 5", rd);
        else n_pass++;
        fsm_halt = 1'b0; load = '0; dec = 4'b0100;
        tick();
        dec = '0; fsm_enable = 1'b1; load = 4'b0100;
        bus_write(6'h28, 32'd9, 2'b10);
        bus_read(6'h28, rd);
        n_checks++;
        if (rd !== 32'd5) $display("FAIL load_old_preload: got %0d expected 5", rd);
        else n_pass++;
        tick();
        load = '0;
        bus_read(6'h28, rd);
        n_checks++;
        if (rd !== 32'd9) $display("FAIL load_new_preload: got %0d expected 9", rd);
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        bus_write(6'h20, 32'hFFFF_1234, 2'b10);
        load = 4'b0001;
        tick();
        load = '0;
        bus_read(6'h20, rd);
        n_checks++;
        if (rd !== 32'h0000_1234) $display("FAIL width_trunc: got %h expected 00001234", rd);
        else n_pass++;
        bus_write(6'h04, 32'h5, 2'b10);
        bus_write(6'h04, 32'hA, 2'b00);
        bus_write(6'h04, 32'hA, 2'b01);
        bus_read(6'h04, rd);
        n_checks++;
        if (rd !== 32'h5) $display("FAIL narrow_write: got %h expected 5", rd);
        else n_pass++;
        bus_write(6'h30, 32'hFFFF, 2'b10);
        bus_write(6'h3C, 32'hFFFF, 2'b10);
        bus_read(6'h30, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL unmapped_30: got %h expected 0", rd);
        else n_pass++;
        bus_read(6'h3C, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL unmapped_3C: got %h expected 0", rd);
        else n_pass++;
        bus_read(6'h10, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL unmapped_10: got %h expected 0", rd);
        else n_pass++;
        bus_write(6'h08, 32'h0000_0F0F, 2'b10);
        bus_read(6'h08, rd);
        n_checks++;
        if (rd !== 32'hF) $display("FAIL mode_swload_reads0: got %h expected f", rd);
        else n_pass++;
        bus_read(6'h20, rd);
        n_checks++;
        if (rd !== 32'h1234) $display("FAIL swload_all_ch0: got %h expected 1234", rd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0]  addr_tab [9] = '{6'h00, 6'h04, 6'h08, 6'h20, 6'h24, 6'h28, 6'h2C, 6'h30, 6'h10};
        logic [5:0]  a;
        logic [31:0] d, rd;
        logic [1:0]  wn;
        for (int cyc = 0; cyc < 400; cyc++) begin
            fsm_halt   = ($urandom_range(0, 9) == 0);
            fsm_enable = ($urandom_range(0, 3) != 0);
            dec        = 4'($urandom);
            load       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 3) == 0) begin
                a  = addr_tab[$urandom_range(0, 8)];
                d  = (a >= 6'h20 && $urandom_range(0, 4) != 0) ? 32'($urandom_range(0, 4)) : $urandom;
                wn = ($urandom_range(0, 4) != 0) ? 2'b10 : 2'($urandom);
                bus_write(a, d, wn);
            end else begin
                tick();
            end
            n_checks++;
            if (zero !== m_zero()) $display("FAIL rand_zero cyc%0d: got %b expected %b", cyc, zero, m_zero());
            else n_pass++;
            n_checks++;
            if (irq !== |(m_status & m_irq_en)) $display("FAIL rand_irq cyc%0d: got %b expected %b", cyc, irq, |(m_status & m_irq_en));
            else n_pass++;
            for (int k = 0; k < 5; k++) begin
                a = (k == 0) ? 6'h00 : 6'(28 + 4 * k);
                bus_read(a, rd);
                n_checks++;
                if (rd !== m_read(a)) $display("FAIL rand_read cyc%0d @%h: got %h expected %h", cyc, a, rd, m_read(a));
                else n_pass++;
            end
        end
        fsm_halt = 1'b0; dec = '0; load = '0;
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        bus_write(6'h20, 32'd7, 2'b10);
        bus_write(6'h08, 32'h100, 2'b10);
        dec = 4'b0001;
        tick();
        rst_n = 1'b0;
        bus_read(6'h20, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL async_reset_count: got %h expected 0", rd);
        else n_pass++;
        n_checks++;
        if (zero !== 4'hF || irq !== 1'b0) $display("FAIL async_reset_flags: got zero=%h irq=%b expected f/0", zero, irq);
        else n_pass++;
        bus_if.address = 6'h08; bus_if.data_in = 32'h0F0F; bus_if.data_write_n = 2'b10;
        @(posedge clk);
        #1;
        bus_if.data_write_n = 2'b11; dec = '0;
        model_reset();
        rst_n = 1'b1;
        tick();
        bus_read(6'h08, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL reset_no_pending_write: got %h expected 0", rd);
        else n_pass++;
        bus_read(6'h00, rd);
        n_checks++;
        if (rd !== 32'h0) $display("FAIL reset_status: got %h expected 0", rd);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_one_shot();
        test_auto_irq();
        test_halt_enable();
        test_decode();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
